// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - execute-stage condition check, deferred flag update and flag save/restore stack
module cond_flag_unit #(
  parameter  int STACK_DEPTH = 4,
  localparam int PTR_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       Valid,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       M_StartS,
  input  logic       MWriteE,
  input  logic [1:0] FlagW,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       MDone,
  input  logic [3:0] MFlags,
  input  logic       Flush,
  input  logic       FlagPush,
  input  logic       FlagPop,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       M_Start,
  output logic       MWrite,
  output logic       Stall,
  output logic [3:0] Flags,
  output logic       C,
  output logic       StackFull,
  output logic       StackEmpty,
  output logic       StackErr
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MC_PEND = 1'b1;

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W-1:0] FULL_OCC = PTR_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

  logic [0:0]       state, nextState;
  logic [1:0]       pendMask, nextMask;
  logic [3:0]       nextFlags, effFlags, stackTop;
  logic [PTR_W-1:0] occ;
  logic [3:0]       stackMem [STACK_DEPTH];
  logic [IDX_W-1:0] pushIdx, popIdx;
  logic             mcDone, condEx, needFlags, go, startMc;
  logic             doPush, doPop, pushOk, popOk;
  logic             fN, fZ, fC, fV;

  assign mcDone = (state == MC_PEND) & MDone;

  // Effective flags: bypass the completing multi-cycle result into the fields it owns
  always_comb begin
    effFlags = Flags;
    if (mcDone) begin
      if (pendMask[1]) effFlags[3:2] = MFlags[3:2];
      if (pendMask[0]) effFlags[1:0] = MFlags[1:0];
    end
  end

  assign {fN, fZ, fC, fV} = effFlags;

  // Condition field evaluation against the effective flags
  always_comb begin
    condEx = 1'b1;
    case (Cond)
      4'b0000: condEx = fZ;
      4'b0001: condEx = ~fZ;
      4'b0010: condEx = fC;
      4'b0011: condEx = ~fC;
      4'b0100: condEx = fN;
      4'b0101: condEx = ~fN;
      4'b0110: condEx = fV;
      4'b0111: condEx = ~fV;
      4'b1000: condEx = fC & ~fZ;
      4'b1001: condEx = ~fC | fZ;
      4'b1010: condEx = (fN == fV);
      4'b1011: condEx = (fN != fV);
      4'b1100: condEx = ~fZ & (fN == fV);
      4'b1101: condEx = fZ | (fN != fV);
      default: condEx = 1'b1;
    endcase
  end

  // An instruction only waits on a pending update if it reads or writes flags or chains another MC op
  assign needFlags = (Cond != 4'b1110) | (|FlagW) | M_StartS;
  assign Stall     = Valid & (state == MC_PEND) & ~MDone & needFlags;
  assign go        = Valid & condEx & ~Stall;
  assign startMc   = go & M_StartS & (|FlagW);

  assign PCSrc    = PCS & go;
  assign RegWrite = RegW & go & ~NoWrite;
  assign MemWrite = MemW & go;
  assign M_Start  = M_StartS & go;
  assign MWrite   = MWriteE & go;

  assign doPush  = FlagPush & ~FlagPop;
  assign doPop   = FlagPop & ~FlagPush;
  assign pushOk  = doPush & (occ != FULL_OCC);
  assign popOk   = doPop & (occ != '0);
  assign pushIdx = IDX_W'(occ);
  assign popIdx  = IDX_W'(occ - ONE);
  assign stackTop = stackMem[popIdx];

  // Next flags/state: resolve pending update, then current instruction, then a restoring pop on top
  always_comb begin
    nextState = state;
    nextMask  = pendMask;
    nextFlags = Flags;
    if (state == IDLE || Flush || MDone) begin
      nextState = IDLE;
      nextMask  = '0;
      if (mcDone && !Flush) nextFlags = effFlags;
      if (startMc) begin
        nextState = MC_PEND;
        nextMask  = FlagW;
      end else if (go && !M_StartS) begin
        if (FlagW[1]) nextFlags[3:2] = ALUFlags[3:2];
        if (FlagW[0]) nextFlags[1:0] = ALUFlags[1:0];
      end
    end
    if (popOk) begin
      nextFlags = stackTop;
      nextState = IDLE;
      nextMask  = '0;
    end
  end

  // Architectural flags, pending-update state and stack occupancy
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      pendMask <= '0;
      Flags    <= '0;
      occ      <= '0;
      StackErr <= 1'b0;
    end else begin
      state    <= nextState;
      pendMask <= nextMask;
      Flags    <= nextFlags;
      if (pushOk)     occ <= occ + ONE;
      else if (popOk) occ <= occ - ONE;
      if ((doPush && !pushOk) || (doPop && !popOk)) StackErr <= 1'b1;
    end
  end

  // Stack storage; contents are only meaningful below the occupancy pointer
  always_ff @(posedge CLK) begin
    if (pushOk) stackMem[pushIdx] <= effFlags;
  end

  assign C          = Flags[1];
  assign StackFull  = (occ == FULL_OCC);
  assign StackEmpty = (occ == '0);

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - randomized and directed self-checking bench for cond_flag_unit
module tb_cond_flag_unit;

  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESETn, Valid, PCS, RegW, MemW, NoWrite, M_StartS, MWriteE;
  logic       MDone, Flush, FlagPush, FlagPop;
  logic [1:0] FlagW;
  logic [3:0] Cond, ALUFlags, MFlags;
  logic       PCSrc, RegWrite, MemWrite, M_Start, MWrite, Stall, C;
  logic       StackFull, StackEmpty, StackErr;
  logic [3:0] Flags;

  cond_flag_unit #(.STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESETn(RESETn), .Valid(Valid), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .M_StartS(M_StartS), .MWriteE(MWriteE), .FlagW(FlagW), .Cond(Cond),
    .ALUFlags(ALUFlags), .MDone(MDone), .MFlags(MFlags), .Flush(Flush), .FlagPush(FlagPush),
    .FlagPop(FlagPop), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .M_Start(M_Start), .MWrite(MWrite), .Stall(Stall), .Flags(Flags), .C(C),
    .StackFull(StackFull), .StackEmpty(StackEmpty), .StackErr(StackErr)
  );

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  logic [3:0] mF;
  bit         mPend;
  logic [1:0] mMask;
  logic [3:0] stk[$];
  bit         mErr;
  logic [3:0] curEf;
  bit         curGo;

  function automatic bit condPass(input logic [3:0] cd, input logic [3:0] f);
    bit n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cd[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (cd == 4'b1111) return 1'b1;
    return cd[0] ? !r : r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic modelReset();
    mF = '0; mPend = 0; mMask = '0; stk.delete(); mErr = 0;
  endtask

  task automatic clearIn();
    Valid = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; M_StartS = 0; MWriteE = 0;
    MDone = 0; Flush = 0; FlagPush = 0; FlagPop = 0; FlagW = '0; Cond = 4'b1110;
    ALUFlags = '0; MFlags = '0;
  endtask

  // Compare every output against the model at the falling edge
  task automatic evalNow();
    bit need, stall;
    logic [15:0] expVec, actVec;
    @(negedge CLK);
    curEf = mF;
    if (mPend && MDone) begin
      curEf[3:2] = mMask[1] ? MFlags[3:2] : mF[3:2];
      curEf[1:0] = mMask[0] ? MFlags[1:0] : mF[1:0];
    end
    need  = (Cond != 4'b1110) || (FlagW != 2'b00) || M_StartS;
    stall = Valid && mPend && !MDone && need;
    curGo = Valid && condPass(Cond, curEf) && !stall;
    expVec = {curGo & PCS, curGo & RegW & !NoWrite, curGo & MemW, curGo & M_StartS,
              curGo & MWriteE, stall, mF, mF[1], stk.size() == DEPTH, stk.size() == 0, mErr};
    actVec = {PCSrc, RegWrite, MemWrite, M_Start, MWrite, Stall, Flags, C,
              StackFull, StackEmpty, StackErr};
    check("cycle", {16'd0, actVec}, {16'd0, expVec});
  endtask

  task automatic commit();
    logic [3:0] nf;
    nf = mF;
    if (mPend && Flush) begin
      mPend = 0; mMask = '0;
    end else if (mPend && MDone) begin
      nf = curEf; mPend = 0; mMask = '0;
    end
    if (curGo) begin
      if (M_StartS && FlagW != 2'b00) begin
        mPend = 1; mMask = FlagW;
      end else if (!M_StartS) begin
        if (FlagW[1]) nf[3:2] = ALUFlags[3:2];
        if (FlagW[0]) nf[1:0] = ALUFlags[1:0];
      end
    end
    if (FlagPush && !FlagPop) begin
      if (stk.size() == DEPTH) mErr = 1;
      else stk.push_back(curEf);
    end
    if (FlagPop && !FlagPush) begin
      if (stk.size() == 0) mErr = 1;
      else begin
        nf = stk.pop_back(); mPend = 0; mMask = '0;
      end
    end
    mF = nf;
    @(posedge CLK);
    #1;
  endtask

  task automatic step();
    evalNow();
    commit();
  endtask

  task automatic resetAll();
    RESETn = 0;
    clearIn();
    modelReset();
    @(posedge CLK);
    #1;
    RESETn = 1;
  endtask

  task automatic aluWrite(input logic [3:0] f);
    clearIn(); Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    step();
    clearIn();
  endtask

  task automatic randIn();
    Valid    = ($urandom_range(0, 3) != 0);
    PCS      = 1'($urandom);
    RegW     = 1'($urandom);
    MemW     = 1'($urandom);
    NoWrite  = ($urandom_range(0, 3) == 0);
    MWriteE  = 1'($urandom);
    M_StartS = ($urandom_range(0, 4) == 0);
    FlagW    = 2'($urandom);
    Cond     = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom);
    ALUFlags = 4'($urandom);
    MDone    = ($urandom_range(0, 3) == 0);
    MFlags   = 4'($urandom);
    Flush    = ($urandom_range(0, 15) == 0);
    FlagPush = ($urandom_range(0, 6) == 0);
    FlagPop  = ($urandom_range(0, 6) == 0);
  endtask

  initial begin
    clearIn();
    modelReset();
    RESETn = 0;
    #12;
    resetAll();

    // Condition gating and plain ALU flag write
    Valid = 1; Cond = 4'b0000; RegW = 1;
    evalNow();
    check("rst_regw_z0", RegWrite, 0);
    check("rst_flags", Flags, 0);
    check("rst_empty", StackEmpty, 1);
    commit();
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
    step();
    Cond = 4'b0000; FlagW = 2'b00;
    evalNow();
    check("subs_flags", Flags, 4'b0100);
    check("subs_regw_z1", RegWrite, 1);
    commit();

    // Deferred NZ update with stall and bypass
    aluWrite(4'b0010);
    Valid = 1; Cond = 4'b1110; FlagW = 2'b10; M_StartS = 1;
    evalNow();
    check("mc_mstart", M_Start, 1);
    commit();
    M_StartS = 0; FlagW = 2'b00; Cond = 4'b0000; RegW = 1;
    repeat (3) begin
      evalNow();
      check("mc_stall", Stall, 1);
      check("mc_regw_held", RegWrite, 0);
      commit();
    end
    MDone = 1; MFlags = 4'b0100;
    evalNow();
    check("mc_done_stall", Stall, 0);
    check("mc_done_regw", RegWrite, 1);
    commit();
    clearIn();
    evalNow();
    check("mc_merged_flags", Flags, 4'b0110);
    commit();

    // Flag-neutral instruction during pending; flush beats done
    Valid = 1; Cond = 4'b1110; FlagW = 2'b11; M_StartS = 1;
    step();
    M_StartS = 0; FlagW = 2'b00; RegW = 1;
    evalNow();
    check("pend_nostall", Stall, 0);
    check("pend_regw", RegWrite, 1);
    commit();
    clearIn(); Flush = 1; MDone = 1; MFlags = 4'b1001;
    step();
    clearIn(); Valid = 1; Cond = 4'b0000; RegW = 1;
    evalNow();
    check("flush_flags", Flags, 4'b0110);
    check("flush_idle", Stall, 0);
    check("flush_regw", RegWrite, 1);
    commit();

    // Stack overflow and LIFO restore
    for (int i = 0; i < 5; i++) begin
      aluWrite(4'(i + 1));
      FlagPush = 1;
      step();
      clearIn();
      if (i == 3) begin
        evalNow();
        check("stk_full", StackFull, 1);
        check("stk_err_pre", StackErr, 0);
        commit();
      end
      if (i == 4) begin
        evalNow();
        check("stk_overflow_err", StackErr, 1);
        commit();
      end
    end
    for (int k = 0; k < 4; k++) begin
      FlagPop = 1;
      step();
      clearIn();
      evalNow();
      check("stk_pop_lifo", Flags, 4'(4 - k));
      commit();
    end
    check("stk_empty", StackEmpty, 1);
    FlagPop = 1;
    step();
    clearIn();
    evalNow();
    check("stk_underflow_flags", Flags, 4'd1);
    commit();

    // Pop beats ALU write; push+pop is a no-op
    resetAll();
    aluWrite(4'b1001);
    FlagPush = 1; step(); step(); clearIn();
    Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111; FlagPop = 1;
    step();
    clearIn();
    evalNow();
    check("pop_beats_alu", Flags, 4'b1001);
    commit();
    FlagPush = 1; FlagPop = 1;
    step();
    clearIn();
    evalNow();
    check("pushpop_occ", StackEmpty, 0);
    check("pushpop_err", StackErr, 0);
    commit();
    FlagPop = 1; step(); clearIn();
    evalNow();
    check("pushpop_one_left", StackEmpty, 1);
    commit();
    FlagPop = 1; step(); clearIn();

    // Asynchronous reset in the middle of a pending update
    FlagPush = 1; step(); step(); clearIn();
    Valid = 1; Cond = 4'b1110; FlagW = 2'b11; M_StartS = 1;
    step();
    M_StartS = 0; FlagW = 2'b00; Cond = 4'b0000;
    evalNow();
    check("pre_rst_stall", Stall, 1);
    commit();
    RESETn = 0;
    #1;
    check("arst_flags", Flags, 0);
    check("arst_stall", Stall, 0);
    check("arst_empty", StackEmpty, 1);
    check("arst_err", StackErr, 0);
    modelReset();
    clearIn();
    @(posedge CLK);
    #1;
    RESETn = 1;

    // Randomized traffic against the model
    repeat (3000) begin
      randIn();
      step();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
